// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencer for the 5-stage RV32 core.
// Latency: enables/flushes are combinational (zero-cycle); state, halt, error and stall count are registered.
// Backpressure: a dmem wait freezes PC..EX/MEM; after MEM_TIMEOUT consecutive wait cycles the core halts with a sticky error.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_hzrd_stall        load-use stall request from the hazard unit
//   i_br_taken          branch/jump taken in EX (redirect PC)
//   i_dmem_req          MEM stage holds a load/store this cycle
//   i_dmem_ready        data memory completes the access this cycle
//   i_halt_req          ebreak/ecall in EX
//   i_resume            debug resume from the halted state
//   o_pc_en .. o_mem_wb_flush  per-stage register enables and flushes
//   o_halted            core halted
//   o_mem_err           sticky dmem timeout error
//   o_stall_cnt         saturating count of stall/freeze cycles
module pipe_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_hzrd_stall,
    input  logic             i_br_taken,
    input  logic             i_dmem_req,
    input  logic             i_dmem_ready,
    input  logic             i_halt_req,
    input  logic             i_resume,
    output logic             o_pc_en,
    output logic             o_if_id_en,
    output logic             o_if_id_flush,
    output logic             o_id_ex_en,
    output logic             o_id_ex_flush,
    output logic             o_ex_mem_en,
    output logic             o_mem_wb_en,
    output logic             o_mem_wb_flush,
    output logic             o_halted,
    output logic             o_mem_err,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        DMEM_WAIT  = 2'd1,
        HALT_DRAIN = 2'd2,
        HALTED     = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [WC_W-1:0]   r_wait_cnt;
    logic [1:0]        r_drain_cnt;
    logic              r_halted;
    logic              r_mem_err;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_freeze;
    logic w_timeout;
    logic w_stall_evt;

    // A halted core has no live MEM-stage access, so dmem handshakes are ignored there.
    assign w_freeze  = i_dmem_req & ~i_dmem_ready & (r_state != HALTED);
    assign w_timeout = w_freeze && (r_wait_cnt == WC_W'(MEM_TIMEOUT - 1));

    always_comb begin
        o_pc_en        = 1'b1;
        o_if_id_en     = 1'b1;
        o_if_id_flush  = 1'b0;
        o_id_ex_en     = 1'b1;
        o_id_ex_flush  = 1'b0;
        o_ex_mem_en    = 1'b1;
        o_mem_wb_en    = 1'b1;
        o_mem_wb_flush = 1'b0;
        w_next         = r_state;
        w_stall_evt    = 1'b0;

        if (i_rst) begin
            o_pc_en        = 1'b0;
            o_if_id_en     = 1'b0;
            o_id_ex_en     = 1'b0;
            o_ex_mem_en    = 1'b0;
            o_mem_wb_en    = 1'b0;
            o_if_id_flush  = 1'b1;
            o_id_ex_flush  = 1'b1;
            o_mem_wb_flush = 1'b1;
            w_next         = RUN;
        end else if (w_freeze) begin
            // Hold everything up to EX/MEM; push a bubble into MEM/WB so the
            // waiting instruction is not retired more than once.
            o_pc_en        = 1'b0;
            o_if_id_en     = 1'b0;
            o_id_ex_en     = 1'b0;
            o_ex_mem_en    = 1'b0;
            o_mem_wb_flush = 1'b1;
            w_stall_evt    = 1'b1;
            if (w_timeout) begin
                w_next = HALTED;
            end else if (r_state == HALT_DRAIN) begin
                w_next = HALT_DRAIN;
            end else begin
                w_next = DMEM_WAIT;
            end
        end else begin
            case (r_state)
                HALTED: begin
                    o_pc_en     = 1'b0;
                    o_if_id_en  = 1'b0;
                    o_id_ex_en  = 1'b0;
                    o_ex_mem_en = 1'b0;
                    o_mem_wb_en = 1'b0;
                    if (i_resume && !r_mem_err) begin
                        w_next = RUN;
                    end
                end
                HALT_DRAIN: begin
                    // Let the instructions already past ID retire; nothing new enters.
                    o_pc_en       = 1'b0;
                    o_if_id_en    = 1'b0;
                    o_id_ex_flush = 1'b1;
                    if (r_drain_cnt == 2'd1) begin
                        w_next = HALTED;
                    end
                end
                default: begin
                    // RUN, or the DMEM_WAIT cycle in which memory completes.
                    w_next = RUN;
                    if (i_halt_req) begin
                        o_pc_en       = 1'b0;
                        o_if_id_flush = 1'b1;
                        o_id_ex_flush = 1'b1;
                        w_next        = HALT_DRAIN;
                    end else if (i_br_taken) begin
                        // ID holds a wrong-path instruction, so any load-use stall on it is moot.
                        o_if_id_flush = 1'b1;
                        o_id_ex_flush = 1'b1;
                    end else if (i_hzrd_stall) begin
                        o_pc_en       = 1'b0;
                        o_if_id_en    = 1'b0;
                        o_id_ex_flush = 1'b1;
                        w_stall_evt   = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_drain_cnt <= 2'd0;
            r_halted    <= 1'b0;
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state  <= w_next;
            r_halted <= (w_next == HALTED);
            // Any non-freeze cycle clears the count, including every HALTED cycle.
            r_wait_cnt <= w_freeze ? (r_wait_cnt + WC_W'(1)) : '0;
            if (r_state == HALT_DRAIN) begin
                if (!w_freeze) begin
                    r_drain_cnt <= r_drain_cnt + 2'd1;
                end
            end else begin
                r_drain_cnt <= 2'd0;
            end
            if (w_timeout) begin
                r_mem_err <= 1'b1;
            end
            if (w_stall_evt && !(&r_stall_cnt)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign o_halted    = r_halted;
    assign o_mem_err   = r_mem_err;
    assign o_stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed-vector bench for pipe_ctrl (MEM_TIMEOUT=4, CNT_W=3).
// Inputs change 1 ns after the rising edge; combinational outputs are sampled 4 ns after it.
// Registered outputs are sampled 1 ns after the edge that updates them.
module tb_pipe_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_hzrd_stall = 1'b0;
    logic       i_br_taken = 1'b0;
    logic       i_dmem_req = 1'b0;
    logic       i_dmem_ready = 1'b0;
    logic       i_halt_req = 1'b0;
    logic       i_resume = 1'b0;
    logic       o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_en, o_id_ex_flush;
    logic       o_ex_mem_en, o_mem_wb_en, o_mem_wb_flush, o_halted, o_mem_err;
    logic [2:0] o_stall_cnt;

    int checks = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    pipe_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_hzrd_stall(i_hzrd_stall), .i_br_taken(i_br_taken),
        .i_dmem_req(i_dmem_req), .i_dmem_ready(i_dmem_ready),
        .i_halt_req(i_halt_req), .i_resume(i_resume),
        .o_pc_en(o_pc_en), .o_if_id_en(o_if_id_en), .o_if_id_flush(o_if_id_flush),
        .o_id_ex_en(o_id_ex_en), .o_id_ex_flush(o_id_ex_flush),
        .o_ex_mem_en(o_ex_mem_en), .o_mem_wb_en(o_mem_wb_en), .o_mem_wb_flush(o_mem_wb_flush),
        .o_halted(o_halted), .o_mem_err(o_mem_err), .o_stall_cnt(o_stall_cnt)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_hzrd_stall = 1'b0; i_br_taken = 1'b0; i_dmem_req = 1'b0;
        i_dmem_ready = 1'b0; i_halt_req = 1'b0; i_resume = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        i_rst = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        i_rst = 1'b1;
        tick();
        #3;
        checks++; if ({o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en} !== 5'b00000) begin
            failures++; $display("FAIL rst_enables got=%b exp=00000", {o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en}); end
        checks++; if ({o_if_id_flush, o_id_ex_flush, o_mem_wb_flush} !== 3'b111) begin
            failures++; $display("FAIL rst_flushes got=%b exp=111", {o_if_id_flush, o_id_ex_flush, o_mem_wb_flush}); end
        checks++; if ({o_halted, o_mem_err, o_stall_cnt} !== 5'b00000) begin
            failures++; $display("FAIL rst_regs got=%b exp=00000", {o_halted, o_mem_err, o_stall_cnt}); end
        tick();
        i_rst = 1'b0;
        #3;
        checks++; if ({o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en, o_if_id_flush, o_id_ex_flush, o_mem_wb_flush} !== 8'b11111000) begin
            failures++; $display("FAIL idle_run got=%b exp=11111000", {o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en, o_if_id_flush, o_id_ex_flush, o_mem_wb_flush}); end
    endtask

    task automatic test_load_use();
        do_reset();
        i_hzrd_stall = 1'b1;
        #3;
        checks++; if ({o_pc_en, o_if_id_en, o_id_ex_flush, o_ex_mem_en, o_mem_wb_en} !== 5'b00111) begin
            failures++; $display("FAIL load_use_ctl got=%b exp=00111", {o_pc_en, o_if_id_en, o_id_ex_flush, o_ex_mem_en, o_mem_wb_en}); end
        tick();
        i_hzrd_stall = 1'b0;
        checks++; if (o_stall_cnt !== 3'd1) begin
            failures++; $display("FAIL load_use_cnt got=%0d exp=1", o_stall_cnt); end
    endtask

    task automatic test_branch_vs_stall();
        do_reset();
        i_br_taken = 1'b1; i_hzrd_stall = 1'b1;
        #3;
        checks++; if ({o_pc_en, o_if_id_flush, o_id_ex_flush, o_ex_mem_en, o_mem_wb_flush} !== 5'b11110) begin
            failures++; $display("FAIL branch_ctl got=%b exp=11110", {o_pc_en, o_if_id_flush, o_id_ex_flush, o_ex_mem_en, o_mem_wb_flush}); end
        tick();
        clear_inputs();
        checks++; if (o_stall_cnt !== 3'd0) begin
            failures++; $display("FAIL branch_cnt got=%0d exp=0", o_stall_cnt); end
    endtask

    task automatic test_dmem_wait();
        do_reset();
        i_dmem_req = 1'b1; i_dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            checks++; if ({o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_flush} !== 5'b00001) begin
                failures++; $display("FAIL dmem_freeze_%0d got=%b exp=00001", i, {o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_flush}); end
            tick();
        end
        i_dmem_ready = 1'b1;
        #3;
        checks++; if ({o_pc_en, o_ex_mem_en, o_mem_wb_en, o_mem_wb_flush} !== 4'b1110) begin
            failures++; $display("FAIL dmem_release got=%b exp=1110", {o_pc_en, o_ex_mem_en, o_mem_wb_en, o_mem_wb_flush}); end
        tick();
        clear_inputs();
        checks++; if ({o_stall_cnt, o_mem_err, o_halted} !== 5'b01100) begin
            failures++; $display("FAIL dmem_after got=%b exp=01100", {o_stall_cnt, o_mem_err, o_halted}); end
    endtask

    task automatic test_timeout();
        do_reset();
        i_dmem_req = 1'b1; i_dmem_ready = 1'b0;
        tick(); tick(); tick();
        checks++; if ({o_halted, o_mem_err} !== 2'b00) begin
            failures++; $display("FAIL timeout_early got=%b exp=00", {o_halted, o_mem_err}); end
        tick();
        checks++; if ({o_halted, o_mem_err, o_stall_cnt} !== 5'b11100) begin
            failures++; $display("FAIL timeout_hit got=%b exp=11100", {o_halted, o_mem_err, o_stall_cnt}); end
        #3;
        checks++; if ({o_pc_en, o_ex_mem_en, o_mem_wb_en, o_mem_wb_flush, o_if_id_flush} !== 5'b00000) begin
            failures++; $display("FAIL timeout_halted_ctl got=%b exp=00000", {o_pc_en, o_ex_mem_en, o_mem_wb_en, o_mem_wb_flush, o_if_id_flush}); end
        i_resume = 1'b1;
        tick();
        tick();
        checks++; if ({o_halted, o_mem_err, o_stall_cnt} !== 5'b11100) begin
            failures++; $display("FAIL timeout_resume_ignored got=%b exp=11100", {o_halted, o_mem_err, o_stall_cnt}); end
        clear_inputs();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        checks++; if ({o_halted, o_mem_err} !== 2'b00) begin
            failures++; $display("FAIL timeout_rst_clear got=%b exp=00", {o_halted, o_mem_err}); end
    endtask

    task automatic test_halt_resume();
        do_reset();
        i_halt_req = 1'b1;
        #3;
        checks++; if ({o_pc_en, o_if_id_flush, o_id_ex_flush, o_ex_mem_en, o_mem_wb_en} !== 5'b01111) begin
            failures++; $display("FAIL halt_req_ctl got=%b exp=01111", {o_pc_en, o_if_id_flush, o_id_ex_flush, o_ex_mem_en, o_mem_wb_en}); end
        tick();
        i_halt_req = 1'b0;
        i_br_taken = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #3;
            checks++; if ({o_halted, o_pc_en, o_if_id_en, o_id_ex_flush, o_ex_mem_en, o_mem_wb_en} !== 6'b000111) begin
                failures++; $display("FAIL drain_%0d got=%b exp=000111", i, {o_halted, o_pc_en, o_if_id_en, o_id_ex_flush, o_ex_mem_en, o_mem_wb_en}); end
            tick();
        end
        i_br_taken = 1'b0;
        checks++; if (o_halted !== 1'b1) begin
            failures++; $display("FAIL halt_reached got=%b exp=1", o_halted); end
        i_resume = 1'b1;
        #3;
        checks++; if ({o_pc_en, o_if_id_en, o_ex_mem_en, o_mem_wb_en} !== 4'b0000) begin
            failures++; $display("FAIL resume_cycle got=%b exp=0000", {o_pc_en, o_if_id_en, o_ex_mem_en, o_mem_wb_en}); end
        tick();
        i_resume = 1'b0;
        #3;
        checks++; if ({o_halted, o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en} !== 6'b011111) begin
            failures++; $display("FAIL resumed_run got=%b exp=011111", {o_halted, o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en}); end
    endtask

    task automatic test_drain_freeze();
        do_reset();
        i_halt_req = 1'b1;
        tick();
        i_halt_req = 1'b0;
        i_dmem_req = 1'b1; i_dmem_ready = 1'b0;
        #3;
        checks++; if ({o_ex_mem_en, o_mem_wb_flush} !== 2'b01) begin
            failures++; $display("FAIL drain_freeze_ctl got=%b exp=01", {o_ex_mem_en, o_mem_wb_flush}); end
        tick();
        i_dmem_req = 1'b0;
        tick();
        checks++; if (o_halted !== 1'b0) begin
            failures++; $display("FAIL drain_freeze_early got=%b exp=0", o_halted); end
        tick();
        checks++; if ({o_halted, o_stall_cnt} !== 4'b1001) begin
            failures++; $display("FAIL drain_freeze_done got=%b exp=1001", {o_halted, o_stall_cnt}); end
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        i_hzrd_stall = 1'b1;
        tick();
        i_hzrd_stall = 1'b0;
        i_halt_req = 1'b1;
        tick();
        i_halt_req = 1'b0;
        i_rst = 1'b1;
        #3;
        checks++; if ({o_pc_en, o_ex_mem_en, o_if_id_flush, o_id_ex_flush, o_mem_wb_flush} !== 5'b00111) begin
            failures++; $display("FAIL mid_drain_rst_ctl got=%b exp=00111", {o_pc_en, o_ex_mem_en, o_if_id_flush, o_id_ex_flush, o_mem_wb_flush}); end
        tick();
        i_rst = 1'b0;
        checks++; if ({o_halted, o_stall_cnt} !== 4'b0000) begin
            failures++; $display("FAIL mid_drain_rst_regs got=%b exp=0000", {o_halted, o_stall_cnt}); end
        tick();
        tick();
        #3;
        checks++; if ({o_halted, o_pc_en, o_if_id_en, o_id_ex_flush} !== 4'b0110) begin
            failures++; $display("FAIL mid_drain_back_to_run got=%b exp=0110", {o_halted, o_pc_en, o_if_id_en, o_id_ex_flush}); end
    endtask

    task automatic test_saturation();
        do_reset();
        i_hzrd_stall = 1'b1;
        repeat (9) tick();
        i_hzrd_stall = 1'b0;
        checks++; if (o_stall_cnt !== 3'd7) begin
            failures++; $display("FAIL stall_cnt_sat got=%0d exp=7", o_stall_cnt); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_vs_stall();
        test_dmem_wait();
        test_timeout();
        test_halt_resume();
        test_drain_freeze();
        test_reset_mid_drain();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
